// File: rtl/b01_pkg.sv
// Shared definitions for the b01 word collector slice.
//   W_DEFAULT : default frame / word width
//   state_e   : collector FSM states
//   word_t    : completed output word {data, ovf} at the default width
package b01_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,  // no frame in progress
    ACC  = 1'b1   // accumulating bits of a frame
  } state_e;

  typedef struct packed {
    logic [W_DEFAULT-1:0] data;
    logic                 ovf;
  } word_t;

endpackage

// File: rtl/b01_word_hold.sv
// One-entry valid/ready holding register for completed words.
// A completed word is loaded when the entry is empty or is being consumed in
// the same cycle. Otherwise it is dropped and the sticky lost flag is set,
// because the serial source upstream cannot be stalled.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : a completed word is presented this cycle
//   load_data_i    : completed word bits
//   load_ovf_i     : completed word overflow summary
//   ready_i        : consumer accepts the held word when valid_o is high
//   clr_flags_i    : synchronous clear of lost_o (a simultaneous set wins)
//   data_o, ovf_o  : held word, stable while valid_o & ~ready_i
//   valid_o        : holding register contains an unconsumed word
//   lost_o         : sticky, a completed word was dropped
module b01_word_hold
  import b01_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         load_ovf_i,
  input  logic         ready_i,
  input  logic         clr_flags_i,
  output logic [W-1:0] data_o,
  output logic         ovf_o,
  output logic         valid_o,
  output logic         lost_o
);

  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic         lost_q, lost_d;
  logic         free;
  logic         take;
  logic         drop;

  always_comb begin
    // NOTE: every variable gets a default before any condition, so no path
    // leaves one unassigned and no latch is inferred.
    data_d  = data_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    // Free when empty, or when the held word leaves on this same edge.
    free = ~valid_q | ready_i;
    take = load_i & free;
    drop = load_i & ~free;

    if (take) begin
      data_d  = load_data_i;
      ovf_d   = load_ovf_i;
      valid_d = 1'b1;
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end

    lost_d = drop | (lost_q & ~clr_flags_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data/ovf storage is reset as well, so the outputs read as
      // zero after reset rather than whatever the flops powered up with.
      data_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the
      // pre-edge values, independent of statement order.
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  assign data_o  = data_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;
  assign lost_o  = lost_q;

endmodule

// File: rtl/b01_word_collector.sv
// Collects the serial result bits (OUTP) and overflow flags (OVERFLW) of the
// b01 comparator/adder FSM, LSB first, into W-bit words and presents each
// completed word on a valid/ready output through a one-word holding register.
// Ports:
//   CLOCK, RESET_N        : clock, asynchronous active-low reset
//   OUTP_IN, OVERFLW_IN   : serial bit and its overflow flag
//   BIT_VALID             : qualifies OUTP_IN / OVERFLW_IN this cycle
//   FRAME_START           : current valid bit is bit 0 of a new frame
//   WORD_DATA, WORD_OVF   : completed word, bit i = i-th received bit;
//                           WORD_OVF = OR of OVERFLW_IN over the frame
//   WORD_VALID/WORD_READY : output handshake
//   LOST                  : sticky, a completed word was dropped
//   SYNC_ERR              : sticky, a frame restarted before completion
//   CLR_FLAGS             : synchronous clear of LOST and SYNC_ERR
module b01_word_collector
  import b01_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  input  logic         OUTP_IN,
  input  logic         OVERFLW_IN,
  input  logic         BIT_VALID,
  input  logic         FRAME_START,
  output logic [W-1:0] WORD_DATA,
  output logic         WORD_OVF,
  output logic         WORD_VALID,
  input  logic         WORD_READY,
  output logic         LOST,
  output logic         SYNC_ERR,
  input  logic         CLR_FLAGS
);

  localparam int unsigned CW = $clog2(W);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic          sync_err_q, sync_err_d;

  logic [W-1:0]  asm_word;   // shift register with the current bit merged in
  logic          last_bit;
  logic          restart;
  logic          word_done;

  // In ACC the counter is never zero: it leaves IDLE at 1 and wraps to 0 only
  // on the edge that returns to IDLE.
  assign last_bit  = (cnt_q == CW'(W - 1));
  assign restart   = BIT_VALID & FRAME_START & (state_q == ACC) & (cnt_q != '0);
  assign word_done = BIT_VALID & ~FRAME_START & (state_q == ACC) & last_bit;

  // State register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (BIT_VALID && FRAME_START) state_d = ACC;
      ACC:     if (word_done)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ovf_acc_d = ovf_acc_q;

    asm_word         = shift_q;
    asm_word[cnt_q]  = OUTP_IN;

    if (BIT_VALID) begin
      if (FRAME_START) begin
        // Opens a frame from IDLE, or restarts one mid-frame: the partial word
        // and accumulator are discarded and this bit becomes bit 0.
        shift_d    = '0;
        shift_d[0] = OUTP_IN;
        ovf_acc_d  = OVERFLW_IN;
        cnt_d      = CW'(1);
      end else if (state_q == ACC) begin
        if (last_bit) begin
          // Word leaves via asm_word this edge; start the next frame clean.
          shift_d   = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
        end else begin
          shift_d   = asm_word;
          ovf_acc_d = ovf_acc_q | OVERFLW_IN;
          cnt_d     = cnt_q + CW'(1);
        end
      end
    end

    // Sticky: a set in the same cycle as CLR_FLAGS wins.
    sync_err_d = restart | (sync_err_q & ~CLR_FLAGS);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      ovf_acc_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ovf_acc_q  <= ovf_acc_d;
      sync_err_q <= sync_err_d;
    end
  end

  b01_word_hold #(
    .W (W)
  ) u_hold (
    .clk         (CLOCK),
    .rst_n       (RESET_N),
    .load_i      (word_done),
    .load_data_i (asm_word),
    .load_ovf_i  (ovf_acc_q | OVERFLW_IN),
    .ready_i     (WORD_READY),
    .clr_flags_i (CLR_FLAGS),
    .data_o      (WORD_DATA),
    .ovf_o       (WORD_OVF),
    .valid_o     (WORD_VALID),
    .lost_o      (LOST)
  );

  assign SYNC_ERR = sync_err_q;

endmodule

// File: tb/tb_b01_word_collector.sv
// Scoreboard bench for b01_word_collector. The driver applies inputs one
// cycle at a time and advances a frame-level reference model (bit queue,
// one-slot occupancy, sticky flags); words the model accepts are queued and a
// separate negedge monitor compares them at every output handshake.
module tb_b01_word_collector;
  import b01_pkg::*;

  localparam int W = W_DEFAULT;

  logic         CLOCK       = 1'b0;
  logic         RESET_N     = 1'b0;
  logic         OUTP_IN     = 1'b0;
  logic         OVERFLW_IN  = 1'b0;
  logic         BIT_VALID   = 1'b0;
  logic         FRAME_START = 1'b0;
  logic [W-1:0] WORD_DATA;
  logic         WORD_OVF;
  logic         WORD_VALID;
  logic         WORD_READY  = 1'b0;
  logic         LOST;
  logic         SYNC_ERR;
  logic         CLR_FLAGS   = 1'b0;

  b01_word_collector #(.W(W)) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .OUTP_IN     (OUTP_IN),
    .OVERFLW_IN  (OVERFLW_IN),
    .BIT_VALID   (BIT_VALID),
    .FRAME_START (FRAME_START),
    .WORD_DATA   (WORD_DATA),
    .WORD_OVF    (WORD_OVF),
    .WORD_VALID  (WORD_VALID),
    .WORD_READY  (WORD_READY),
    .LOST        (LOST),
    .SYNC_ERR    (SYNC_ERR),
    .CLR_FLAGS   (CLR_FLAGS)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_bits[$];
  bit     m_inframe;
  bit     m_ovf;
  bit     m_busy;
  bit     m_lost;
  bit     m_sync;
  word_t  exp_q[$];

  // Monitor observations
  logic [W-1:0] last_data;
  logic         last_ovf;
  int           pops = 0;
  int           valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs being applied.
  task automatic model_edge();
    bit    done     = 1'b0;
    bit    sync_set = 1'b0;
    bit    lost_set = 1'b0;
    bit    free;
    word_t w;
    w = '0;
    if (BIT_VALID) begin
      if (FRAME_START) begin
        if (m_inframe) sync_set = 1'b1;
        m_bits    = {};
        m_bits.push_back(int'(OUTP_IN));
        m_ovf     = OVERFLW_IN;
        m_inframe = 1'b1;
      end else if (m_inframe) begin
        m_bits.push_back(int'(OUTP_IN));
        m_ovf = m_ovf | OVERFLW_IN;
      end
      if (m_inframe && m_bits.size() == W) begin
        done = 1'b1;
        foreach (m_bits[i]) w.data[i] = m_bits[i][0];
        w.ovf     = m_ovf;
        m_bits    = {};
        m_inframe = 1'b0;
        m_ovf     = 1'b0;
      end
    end
    free = !m_busy || WORD_READY;
    if (m_busy && WORD_READY) m_busy = 1'b0;
    if (done) begin
      if (free) begin
        exp_q.push_back(w);
        m_busy = 1'b1;
      end else begin
        lost_set = 1'b1;
      end
    end
    if (lost_set) m_lost = 1'b1;
    else if (CLR_FLAGS) m_lost = 1'b0;
    if (sync_set) m_sync = 1'b1;
    else if (CLR_FLAGS) m_sync = 1'b0;
  endtask

  // Called at posedge+1; applies inputs, lets one edge pass, returns at posedge+1.
  task automatic step(input logic v, input logic fs, input logic b, input logic o,
                      input logic rdy, input logic clr);
    BIT_VALID   = v;
    FRAME_START = fs;
    OUTP_IN     = b;
    OVERFLW_IN  = o;
    WORD_READY  = rdy;
    CLR_FLAGS   = clr;
    @(posedge CLOCK);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic [W-1:0] om,
                            input logic rdy, input logic rdy_last,
                            input int gap_after, input int gaps);
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), d[i], om[i], (i == W - 1) ? rdy_last : rdy, 1'b0);
      if (i == gap_after) idle(gaps, rdy);
    end
  endtask

  task automatic do_reset(input int cycles);
    RESET_N     = 1'b0;
    BIT_VALID   = 1'b0;
    FRAME_START = 1'b0;
    OUTP_IN     = 1'b0;
    OVERFLW_IN  = 1'b0;
    WORD_READY  = 1'b0;
    CLR_FLAGS   = 1'b0;
    #1;
    check("rst_word_data",  WORD_DATA,  '0);
    check("rst_word_ovf",   WORD_OVF,   0);
    check("rst_word_valid", WORD_VALID, 0);
    check("rst_lost",       LOST,       0);
    check("rst_sync_err",   SYNC_ERR,   0);
    m_bits    = {};
    m_inframe = 1'b0;
    m_ovf     = 1'b0;
    m_busy    = 1'b0;
    m_lost    = 1'b0;
    m_sync    = 1'b0;
    exp_q     = {};
    repeat (cycles) @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
  endtask

  // Monitor: per-cycle status against the model, words at each handshake.
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      check("word_valid", WORD_VALID, m_busy);
      check("lost",       LOST,       m_lost);
      check("sync_err",   SYNC_ERR,   m_sync);
      if (WORD_VALID) valid_cycles++;
      if (WORD_VALID && WORD_READY) begin
        check("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          word_t e;
          e = exp_q.pop_front();
          check("word_data", WORD_DATA, e.data);
          check("word_ovf",  WORD_OVF,  e.ovf);
          last_data = WORD_DATA;
          last_ovf  = WORD_OVF;
          pops++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pops0;
    @(posedge CLOCK);
    #1;
    do_reset(3);

    // 1: plain frame 0x4D, valid exactly one cycle
    valid_cycles = 0;
    send_frame(8'h4D, 8'h00, 1'b1, 1'b1, -1, 0);
    idle(3, 1'b1);
    check("t1_data", last_data, 8'h4D);
    check("t1_ovf", last_ovf, 0);
    check("t1_valid_cycles", valid_cycles, 1);

    // 2: overflow on bit 5, three idle cycles after bit 2
    send_frame(8'h4D, 8'h20, 1'b1, 1'b1, 2, 3);
    idle(2, 1'b1);
    check("t2_data", last_data, 8'h4D);
    check("t2_ovf", last_ovf, 1);

    // 3: consumer stalled, second word dropped
    send_frame(8'hA5, 8'h00, 1'b0, 1'b0, -1, 0);
    send_frame(8'h3C, 8'h00, 1'b0, 1'b0, -1, 0);
    idle(1, 1'b0);
    check("t3_lost", LOST, 1);
    check("t3_held", WORD_DATA, 8'hA5);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("t3_consumed", last_data, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    check("t3_lost_clr", LOST, 0);

    // 4: consume and load on the same edge
    send_frame(8'h11, 8'h00, 1'b0, 1'b0, -1, 0);
    send_frame(8'h22, 8'h01, 1'b0, 1'b1, -1, 0);
    idle(1, 1'b0);
    check("t4_first", last_data, 8'h11);
    check("t4_valid", WORD_VALID, 1);
    check("t4_data", WORD_DATA, 8'h22);
    check("t4_lost", LOST, 0);
    idle(2, 1'b1);

    // 5: restart after 4 bits, then a full 0xFF frame
    pops0 = pops;
    for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 8'h00, 1'b1, 1'b1, -1, 0);
    idle(2, 1'b1);
    check("t5_sync_err", SYNC_ERR, 1);
    check("t5_data", last_data, 8'hFF);
    check("t5_words", pops - pops0, 1);

    // 6: reset mid-frame, then a clean 0x3C frame
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    send_frame(8'h3C, 8'h00, 1'b1, 1'b1, -1, 0);
    idle(2, 1'b1);
    check("t6_data", last_data, 8'h3C);
    check("t6_lost", LOST, 0);
    check("t6_sync_err", SYNC_ERR, 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, fs, b, o, rdy, clr;
      v   = ($urandom_range(0, 9) < 7);
      fs  = v && (m_inframe ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 2) == 0));
      b   = 1'($urandom_range(0, 1));
      o   = ($urandom_range(0, 7) == 0);
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 49) == 0);
      step(v, fs, b, o, rdy, clr);
      if (n == 1500) do_reset(2);
    end

    idle(4, 1'b1);
    check("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b01_word_collector.md
Name: b01_word_collector

Overview:
- Downstream stage of the b01 serial comparator/adder FSM. It consumes that FSM's serial result bit (OUTP) and its overflow flag (OVERFLW), one bit per strobe, LSB first.
- Assembles each frame of W bits into a parallel word plus an overflow summary.
- Presents completed words on a valid/ready output with a one-word holding register.
- The serial source cannot be stalled, so a word that finds the holding register occupied is dropped and flagged.

Parameters:
- W, 8, bits per frame / output word width (W >= 2).
- CW, $clog2(W), bit-position counter width (derived; not overridden).

Ports:
- CLOCK  input  1  single clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- OUTP_IN  input  1  serial result bit from the b01 FSM.
- OVERFLW_IN  input  1  overflow flag from the b01 FSM, sampled with each bit.
- BIT_VALID  input  1  qualifies OUTP_IN/OVERFLW_IN this cycle.
- FRAME_START  input  1  marks the current valid bit as bit 0 of a new frame; ignored when BIT_VALID=0.
- WORD_DATA  output  W  completed word; bit i = i-th received bit.
- WORD_OVF  output  1  OR of OVERFLW_IN over all W bits of the frame.
- WORD_VALID  output  1  holding register contains an unconsumed word.
- WORD_READY  input  1  consumer accepts the word when WORD_VALID & WORD_READY.
- LOST  output  1  sticky: a completed word was dropped.
- SYNC_ERR  output  1  sticky: a frame restarted before completion.
- CLR_FLAGS  input  1  synchronous clear of LOST and SYNC_ERR.

Behaviour:
- Reset (async assert, sync-safe deassert): cnt=0, shift register=0, ovf accumulator=0, state=IDLE, WORD_DATA=0, WORD_OVF=0, WORD_VALID=0, LOST=0, SYNC_ERR=0.
- FSM states:
  - IDLE: no frame in progress. BIT_VALID&FRAME_START -> ACC with bit 0 stored, cnt=1. BIT_VALID without FRAME_START is discarded; stay in IDLE.
  - ACC: each BIT_VALID stores OUTP_IN at position cnt, ORs OVERFLW_IN into the accumulator, and increments cnt.
  - Bit W-1 accepted: word complete; cnt=0; -> IDLE.
- FRAME_START with BIT_VALID while in ACC and cnt != 0:
  - Set SYNC_ERR and discard the partial word and accumulator.
  - The current bit becomes bit 0 of the new frame; cnt=1; stay in ACC.
- Completion transfer, same edge the last bit is accepted. The holding register is free if WORD_VALID=0, or if WORD_VALID&WORD_READY in that cycle (simultaneous consume and load, no bubble).
  - Free: load WORD_DATA = assembled word and WORD_OVF = accumulator | OVERFLW_IN of the last bit; WORD_VALID=1.
  - Not free: drop the new word, set LOST; the held word is untouched.
- Latency: WORD_VALID rises on the cycle after the edge that accepted bit W-1.
- WORD_VALID&WORD_READY without a new completion: WORD_VALID=0 next cycle; WORD_DATA holds its value (no requirement to clear).
- WORD_DATA/WORD_OVF are stable while WORD_VALID=1 and WORD_READY=0.
- Sticky flags: CLR_FLAGS clears them. If set and clear coincide, set wins.
- Gaps: BIT_VALID=0 cycles inside a frame hold all state; no timeout.
- RESET_N asserted mid-frame or with a held word: everything returns to reset values; the partial/held word is lost without setting LOST.

Decomposition:
- Shared package b01_pkg:
  - state enum {IDLE, ACC};
  - default W constant;
  - a typedef for the output word {data[W-1:0], ovf}.
- One natural sub-module, b01_word_hold: the one-entry valid/ready holding register with load/drop arbitration and the LOST flag.
- Parent keeps the FSM, counter, shift register and SYNC_ERR.

Test Plan:
1. W=8, FRAME_START on first bit, bits 1,0,1,1,0,0,1,0 on consecutive cycles, OVERFLW_IN=0, WORD_READY=1 -> WORD_DATA=8'h4D, WORD_OVF=0, WORD_VALID high exactly 1 cycle, the cycle after the 8th bit.
2. Same frame with OVERFLW_IN=1 only on bit 5, and 3 idle cycles inserted between bits 2 and 3 -> WORD_DATA=8'h4D, WORD_OVF=1.
3. WORD_READY=0; send two full frames -> first word held unchanged, LOST=1 after the second frame's last bit. WORD_READY=1 then consumes the first word; CLR_FLAGS -> LOST=0.
4. WORD_VALID=1 with WORD_READY=1 asserted on the exact cycle a second frame completes -> second word loaded, WORD_VALID stays 1, LOST stays 0.
5. Send 4 bits, then FRAME_START with a full 8-bit frame of 0xFF -> SYNC_ERR=1, WORD_DATA=8'hFF, no word for the partial frame.
6. Assert RESET_N=0 for 1 cycle after 5 bits, then a clean frame 0x3C -> all outputs 0 during reset, then WORD_DATA=8'h3C, LOST=0, SYNC_ERR=0.
